vga_bitmap_scaler: RTL and testbench

- Parametrised VGA timing generator plus scaled monochrome bitmap renderer; generalises the fixed 640x480 / 8x8-bitmap display block.
- Timing, bitmap size, integer scale, window position, sync polarity and colours are configurable.
- Bitmap is captured once per frame at the start of vertical blanking, so the displayed image never tears.
- Sits between the memory/bitmap source and the VGA DAC pins.

---
 rtl/vga_bitmap_scaler_if.sv | 28 ++
 rtl/vga_bitmap_scaler.sv | 183 ++++++++++++++++++
 tb/tb_vga_bitmap_scaler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_bitmap_scaler_if.sv
// Pixel-side bundle of the bitmap scaler.
// The master side drives the bitmap and colours; the slave side (the scaler) drives the VGA pins.
interface vga_bitmap_scaler_if #(
   parameter int BMP_W = 8,
   parameter int BMP_H = 8
);
   logic [BMP_W*BMP_H-1:0] vdata;
   logic [11:0]            fg_color;
   logic [11:0]            bg_color;
   logic                   hsync;
   logic                   vsync;
   logic [3:0]             red;
   logic [3:0]             green;
   logic [3:0]             blue;
   logic                   de;
   logic                   frame_start;
   logic                   vdata_latched;

   modport master (
      output vdata, fg_color, bg_color,
      input  hsync, vsync, red, green, blue, de, frame_start, vdata_latched
   );

   modport slave (
      input  vdata, fg_color, bg_color,
      output hsync, vsync, red, green, blue, de, frame_start, vdata_latched
   );
endinterface

// File: rtl/vga_bitmap_scaler.sv
// VGA timing generator with a scaled monochrome bitmap window.
// The bitmap is shadowed once per frame on entry to vertical blank; all outputs are registered.
module vga_bitmap_scaler #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_PULSE  = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_PULSE  = 2,
   parameter int V_BP     = 33,
   parameter int BMP_W    = 8,
   parameter int BMP_H    = 8,
   parameter int SCALE    = 8,
   parameter int X0       = 288,
   parameter int Y0       = 208,
   parameter int SYNC_POL = 0
) (
   input logic                dclk,
   input logic                clr,
   vga_bitmap_scaler_if.slave vif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;
   localparam int NBITS   = BMP_W * BMP_H;
   localparam int HC_W    = $clog2(H_TOTAL + 1);
   localparam int VC_W    = $clog2(V_TOTAL + 1);
   localparam int COL_W   = $clog2(BMP_W + 1);
   localparam int ROW_W   = $clog2(BMP_H + 1);
   localparam int SUB_W   = $clog2(SCALE + 1);
   localparam int IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;

   localparam logic [HC_W-1:0] HC_LAST = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0] HC_ACT  = HC_W'(H_ACTIVE);
   localparam logic [HC_W-1:0] HS_ON   = HC_W'(H_ACTIVE + H_FP);
   localparam logic [HC_W-1:0] HS_OFF  = HC_W'(H_ACTIVE + H_FP + H_PULSE);
   localparam logic [HC_W-1:0] WX0     = HC_W'(X0);
   localparam logic [HC_W-1:0] WX_SPAN = HC_W'(BMP_W * SCALE);
   localparam logic [VC_W-1:0] VC_LAST = VC_W'(V_TOTAL - 1);
   localparam logic [VC_W-1:0] VC_ACT  = VC_W'(V_ACTIVE);
   localparam logic [VC_W-1:0] VC_CAP  = VC_W'(V_ACTIVE - 1);
   localparam logic [VC_W-1:0] VS_ON   = VC_W'(V_ACTIVE + V_FP);
   localparam logic [VC_W-1:0] VS_OFF  = VC_W'(V_ACTIVE + V_FP + V_PULSE);
   localparam logic [VC_W-1:0] WY0     = VC_W'(Y0);
   localparam logic [VC_W-1:0] WY_SPAN = VC_W'(BMP_H * SCALE);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
   localparam logic            SYNC_ON  = (SYNC_POL != 0);

   if (SCALE < 1) begin : g_chk_scale
      $error("vga_bitmap_scaler: SCALE must be at least 1");
   end
   if (X0 + BMP_W * SCALE > H_ACTIVE) begin : g_chk_x
      $error("vga_bitmap_scaler: bitmap window exceeds H_ACTIVE");
   end
   if (Y0 + BMP_H * SCALE > V_ACTIVE) begin : g_chk_y
      $error("vga_bitmap_scaler: bitmap window exceeds V_ACTIVE");
   end

   logic [HC_W-1:0]  hc_q, hc_d;
   logic [VC_W-1:0]  vc_q, vc_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [SUB_W-1:0] csub_q, csub_d;
   logic [SUB_W-1:0] rsub_q, rsub_d;
   logic [NBITS-1:0] shadow_q, shadow_d;
   logic [11:0]      rgb_q, rgb_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             de_q, de_d;
   logic             frame_start_q, frame_start_d;
   logic             vdata_latched_q, vdata_latched_d;

   logic             line_end;
   logic             active;
   logic             in_wx;
   logic             in_wy;
   logic             capture;
   logic [HC_W-1:0]  hx_rel;
   logic [VC_W-1:0]  vy_rel;
   logic [IDX_W-1:0] bit_idx;

   always_comb begin
      line_end = (hc_q == HC_LAST);
      hc_d     = line_end ? '0 : hc_q + HC_W'(1);
      vc_d     = vc_q;
      if (line_end) begin
         vc_d = (vc_q == VC_LAST) ? '0 : vc_q + VC_W'(1);
      end

      // Modular offset: positions left of / above the window wrap to large values,
      // so one compare covers both window edges.
      hx_rel = hc_q - WX0;
      vy_rel = vc_q - WY0;
      in_wx  = (hx_rel < WX_SPAN);
      in_wy  = (vy_rel < WY_SPAN);
      active = (hc_q < HC_ACT) && (vc_q < VC_ACT);

      col_d  = col_q;
      csub_d = csub_q;
      if (hc_d == WX0) begin
         col_d  = '0;
         csub_d = '0;
      end else if (in_wx) begin
         if (csub_q == SUB_LAST) begin
            csub_d = '0;
            col_d  = col_q + COL_W'(1);
         end else begin
            csub_d = csub_q + SUB_W'(1);
         end
      end

      row_d  = row_q;
      rsub_d = rsub_q;
      if (line_end) begin
         if (vc_d == WY0) begin
            row_d  = '0;
            rsub_d = '0;
         end else if (in_wy) begin
            if (rsub_q == SUB_LAST) begin
               rsub_d = '0;
               row_d  = row_q + ROW_W'(1);
            end else begin
               rsub_d = rsub_q + SUB_W'(1);
            end
         end
      end

      bit_idx = IDX_W'(int'(row_q) * BMP_W + int'(col_q));
      rgb_d   = '0;
      if (active && in_wx && in_wy) begin
         rgb_d = shadow_q[bit_idx] ? vif.fg_color : vif.bg_color;
      end

      hsync_d         = ((hc_q >= HS_ON) && (hc_q < HS_OFF)) ? SYNC_ON : ~SYNC_ON;
      vsync_d         = ((vc_q >= VS_ON) && (vc_q < VS_OFF)) ? SYNC_ON : ~SYNC_ON;
      de_d            = active;
      frame_start_d   = (hc_q == '0) && (vc_q == '0);
      capture         = line_end && (vc_q == VC_CAP);
      shadow_d        = capture ? vif.vdata : shadow_q;
      vdata_latched_d = capture;
   end

   always_ff @(posedge dclk) begin
      if (!clr) begin
         hc_q            <= '0;
         vc_q            <= '0;
         col_q           <= '0;
         row_q           <= '0;
         csub_q          <= '0;
         rsub_q          <= '0;
         shadow_q        <= '0;
         rgb_q           <= '0;
         hsync_q         <= ~SYNC_ON;
         vsync_q         <= ~SYNC_ON;
         de_q            <= 1'b0;
         frame_start_q   <= 1'b0;
         vdata_latched_q <= 1'b0;
      end else begin
         hc_q            <= hc_d;
         vc_q            <= vc_d;
         col_q           <= col_d;
         row_q           <= row_d;
         csub_q          <= csub_d;
         rsub_q          <= rsub_d;
         shadow_q        <= shadow_d;
         rgb_q           <= rgb_d;
         hsync_q         <= hsync_d;
         vsync_q         <= vsync_d;
         de_q            <= de_d;
         frame_start_q   <= frame_start_d;
         vdata_latched_q <= vdata_latched_d;
      end
   end

   assign vif.hsync         = hsync_q;
   assign vif.vsync         = vsync_q;
   assign vif.red           = rgb_q[11:8];
   assign vif.green         = rgb_q[7:4];
   assign vif.blue          = rgb_q[3:0];
   assign vif.de            = de_q;
   assign vif.frame_start   = frame_start_q;
   assign vif.vdata_latched = vdata_latched_q;
endmodule

// File: tb/tb_vga_bitmap_scaler.sv
// Directed bench for vga_bitmap_scaler using three reduced-timing instances:
// A = 80x55 total, 8x8 bitmap x2; B = 22x14, 2x2 bitmap x2, active-high syncs; C = 40x20, 8x8 x1 at right edge.
module tb_vga_bitmap_scaler;
   logic dclk = 1'b0;
   logic clr_a = 1'b0;
   logic clr_b = 1'b0;
   logic clr_c = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   t0_a = 0;
   int   t0_b = 0;
   int   t0_c = 0;

   always #5 dclk = ~dclk;
   always @(posedge dclk) cyc <= cyc + 1;

   vga_bitmap_scaler_if #(.BMP_W(8), .BMP_H(8)) if_a ();
   vga_bitmap_scaler_if #(.BMP_W(2), .BMP_H(2)) if_b ();
   vga_bitmap_scaler_if #(.BMP_W(8), .BMP_H(8)) if_c ();

   vga_bitmap_scaler #(
      .H_ACTIVE(64), .H_FP(4), .H_PULSE(8), .H_BP(4),
      .V_ACTIVE(48), .V_FP(2), .V_PULSE(2), .V_BP(3),
      .BMP_W(8), .BMP_H(8), .SCALE(2), .X0(24), .Y0(16), .SYNC_POL(0)
   ) dut_a (.dclk(dclk), .clr(clr_a), .vif(if_a));

   vga_bitmap_scaler #(
      .H_ACTIVE(16), .H_FP(2), .H_PULSE(2), .H_BP(2),
      .V_ACTIVE(8), .V_FP(2), .V_PULSE(2), .V_BP(2),
      .BMP_W(2), .BMP_H(2), .SCALE(2), .X0(0), .Y0(0), .SYNC_POL(1)
   ) dut_b (.dclk(dclk), .clr(clr_b), .vif(if_b));

   vga_bitmap_scaler #(
      .H_ACTIVE(32), .H_FP(2), .H_PULSE(4), .H_BP(2),
      .V_ACTIVE(16), .V_FP(1), .V_PULSE(2), .V_BP(1),
      .BMP_W(8), .BMP_H(8), .SCALE(1), .X0(24), .Y0(4), .SYNC_POL(0)
   ) dut_c (.dclk(dclk), .clr(clr_c), .vif(if_c));

   function automatic int pos_a(input int f, input int v, input int h);
      return (f * 55 + v) * 80 + h;
   endfunction
   function automatic int pos_b(input int f, input int v, input int h);
      return (f * 14 + v) * 22 + h;
   endfunction
   function automatic int pos_c(input int f, input int v, input int h);
      return (f * 20 + v) * 40 + h;
   endfunction

   // Output position k (counted from release) is visible at the negedge where cyc - t0 == k + 1.
   task automatic goto(input int t0, input int k);
      while ((cyc - t0) < k + 1) @(negedge dclk);
      if ((cyc - t0) != k + 1) begin
         n_err++;
         $display("FAIL seq: at position %0d, wanted %0d", cyc - t0 - 1, k);
      end
   endtask

   task automatic test_reset();
      repeat (5) @(posedge dclk);
      @(negedge dclk);
      n_vec++; if (if_a.hsync !== 1'b1) begin n_err++; $display("FAIL rst_a_hsync: got %b want 1", if_a.hsync); end
      n_vec++; if (if_a.vsync !== 1'b1) begin n_err++; $display("FAIL rst_a_vsync: got %b want 1", if_a.vsync); end
      n_vec++; if ({if_a.red, if_a.green, if_a.blue} !== 12'h000) begin n_err++; $display("FAIL rst_a_rgb: got %h want 000", {if_a.red, if_a.green, if_a.blue}); end
      n_vec++; if (if_a.de !== 1'b0) begin n_err++; $display("FAIL rst_a_de: got %b want 0", if_a.de); end
      n_vec++; if (if_a.frame_start !== 1'b0) begin n_err++; $display("FAIL rst_a_fs: got %b want 0", if_a.frame_start); end
      n_vec++; if (if_a.vdata_latched !== 1'b0) begin n_err++; $display("FAIL rst_a_vl: got %b want 0", if_a.vdata_latched); end
      n_vec++; if (if_b.hsync !== 1'b0) begin n_err++; $display("FAIL rst_b_hsync: got %b want 0", if_b.hsync); end
      n_vec++; if (if_b.vsync !== 1'b0) begin n_err++; $display("FAIL rst_b_vsync: got %b want 0", if_b.vsync); end
   endtask

   task automatic test_sync_timing();
      int hs_low = 0;
      int vs_low = 0;
      int de_hi = 0;
      int fs_cnt = 0;
      int fs_pos[2] = '{-1, -1};
      int h;
      int v;
      clr_a = 1'b1;
      t0_a  = cyc;
      for (int k = 0; k < 2 * 4400; k++) begin
         goto(t0_a, k);
         h = k % 80;
         v = (k / 80) % 55;
         if (if_a.hsync === 1'b0) hs_low++;
         if (if_a.vsync === 1'b0) vs_low++;
         if (if_a.de === 1'b1) de_hi++;
         if (if_a.frame_start === 1'b1) begin
            if (fs_cnt < 2) fs_pos[fs_cnt] = k;
            fs_cnt++;
         end
         if (h == 67 || h == 76) begin
            n_vec++; if (if_a.hsync !== 1'b1) begin n_err++; $display("FAIL hs_edge_off(v=%0d,h=%0d): got %b want 1", v, h, if_a.hsync); end
         end
         if (h == 68 || h == 75) begin
            n_vec++; if (if_a.hsync !== 1'b0) begin n_err++; $display("FAIL hs_edge_on(v=%0d,h=%0d): got %b want 0", v, h, if_a.hsync); end
         end
         if (h == 0 && (v == 49 || v == 52)) begin
            n_vec++; if (if_a.vsync !== 1'b1) begin n_err++; $display("FAIL vs_edge_off(v=%0d): got %b want 1", v, if_a.vsync); end
         end
         if (h == 0 && (v == 50 || v == 51)) begin
            n_vec++; if (if_a.vsync !== 1'b0) begin n_err++; $display("FAIL vs_edge_on(v=%0d): got %b want 0", v, if_a.vsync); end
         end
      end
      n_vec++; if (hs_low != 880) begin n_err++; $display("FAIL hs_low_count: got %0d want 880", hs_low); end
      n_vec++; if (vs_low != 320) begin n_err++; $display("FAIL vs_low_count: got %0d want 320", vs_low); end
      n_vec++; if (de_hi != 6144) begin n_err++; $display("FAIL de_count: got %0d want 6144", de_hi); end
      n_vec++; if (fs_cnt != 2) begin n_err++; $display("FAIL fs_count: got %0d want 2", fs_cnt); end
      n_vec++; if (fs_pos[0] != 0) begin n_err++; $display("FAIL fs_first: got %0d want 0", fs_pos[0]); end
      n_vec++; if (fs_pos[1] != 4400) begin n_err++; $display("FAIL fs_period: got %0d want 4400", fs_pos[1]); end
   endtask

   task automatic test_image();
      int          tv[7] = '{15, 16, 16, 16, 16, 17, 18};
      int          th[7] = '{24, 23, 24, 26, 40, 25, 24};
      logic [11:0] te[7] = '{12'h000, 12'h000, 12'hFFF, 12'h00F, 12'h000, 12'hFFF, 12'h00F};
      if_a.fg_color = 12'hFFF;
      if_a.bg_color = 12'h000;
      if_a.vdata    = 64'h1;
      clr_a = 1'b0;
      repeat (2) @(negedge dclk);
      clr_a = 1'b1;
      t0_a  = cyc;
      goto(t0_a, pos_a(0, 16, 24));
      n_vec++; if ({if_a.red, if_a.green, if_a.blue} !== 12'h000) begin n_err++; $display("FAIL img_black_f0: got %h want 000", {if_a.red, if_a.green, if_a.blue}); end
      n_vec++; if (if_a.de !== 1'b1) begin n_err++; $display("FAIL img_de_f0: got %b want 1", if_a.de); end
      goto(t0_a, pos_a(1, 0, 0));
      if_a.bg_color = 12'h00F;
      for (int i = 0; i < 7; i++) begin
         goto(t0_a, pos_a(1, tv[i], th[i]));
         n_vec++;
         if ({if_a.red, if_a.green, if_a.blue} !== te[i]) begin
            n_err++;
            $display("FAIL img_f1(v=%0d,h=%0d): got %h want %h", tv[i], th[i], {if_a.red, if_a.green, if_a.blue}, te[i]);
         end
      end
   endtask

   task automatic test_vdata_change();
      int          tv[5] = '{16, 29, 30, 30, 31};
      int          th[5] = '{24, 38, 37, 38, 39};
      logic [11:0] te[5] = '{12'h00F, 12'h00F, 12'h00F, 12'hFFF, 12'hFFF};
      goto(t0_a, pos_a(1, 24, 0));
      if_a.vdata = 64'h8000_0000_0000_0000;
      goto(t0_a, pos_a(1, 30, 38));
      n_vec++; if ({if_a.red, if_a.green, if_a.blue} !== 12'h00F) begin n_err++; $display("FAIL chg_old_f1a: got %h want 00F", {if_a.red, if_a.green, if_a.blue}); end
      goto(t0_a, pos_a(1, 31, 39));
      n_vec++; if ({if_a.red, if_a.green, if_a.blue} !== 12'h00F) begin n_err++; $display("FAIL chg_old_f1b: got %h want 00F", {if_a.red, if_a.green, if_a.blue}); end
      goto(t0_a, pos_a(1, 32, 24));
      n_vec++; if ({if_a.red, if_a.green, if_a.blue} !== 12'h000) begin n_err++; $display("FAIL chg_below_win: got %h want 000", {if_a.red, if_a.green, if_a.blue}); end
      goto(t0_a, pos_a(1, 47, 78));
      n_vec++; if (if_a.vdata_latched !== 1'b0) begin n_err++; $display("FAIL vl_early: got %b want 0", if_a.vdata_latched); end
      goto(t0_a, pos_a(1, 47, 79));
      n_vec++; if (if_a.vdata_latched !== 1'b1) begin n_err++; $display("FAIL vl_pulse: got %b want 1", if_a.vdata_latched); end
      goto(t0_a, pos_a(1, 48, 0));
      n_vec++; if (if_a.vdata_latched !== 1'b0) begin n_err++; $display("FAIL vl_late: got %b want 0", if_a.vdata_latched); end
      for (int i = 0; i < 5; i++) begin
         goto(t0_a, pos_a(2, tv[i], th[i]));
         n_vec++;
         if ({if_a.red, if_a.green, if_a.blue} !== te[i]) begin
            n_err++;
            $display("FAIL chg_f2(v=%0d,h=%0d): got %h want %h", tv[i], th[i], {if_a.red, if_a.green, if_a.blue}, te[i]);
         end
      end
   endtask

   task automatic test_midframe_reset();
      goto(t0_a, pos_a(2, 40, 70));
      n_vec++; if (if_a.hsync !== 1'b0) begin n_err++; $display("FAIL mrst_pre_hsync: got %b want 0", if_a.hsync); end
      if_a.bg_color = 12'h000;
      clr_a = 1'b0;
      @(negedge dclk);
      n_vec++; if (if_a.hsync !== 1'b1) begin n_err++; $display("FAIL mrst_hsync: got %b want 1", if_a.hsync); end
      n_vec++; if (if_a.vsync !== 1'b1) begin n_err++; $display("FAIL mrst_vsync: got %b want 1", if_a.vsync); end
      n_vec++; if ({if_a.red, if_a.green, if_a.blue} !== 12'h000) begin n_err++; $display("FAIL mrst_rgb: got %h want 000", {if_a.red, if_a.green, if_a.blue}); end
      n_vec++; if (if_a.de !== 1'b0) begin n_err++; $display("FAIL mrst_de: got %b want 0", if_a.de); end
      n_vec++; if (if_a.frame_start !== 1'b0) begin n_err++; $display("FAIL mrst_fs: got %b want 0", if_a.frame_start); end
      clr_a = 1'b1;
      t0_a  = cyc;
      goto(t0_a, 0);
      n_vec++; if (if_a.frame_start !== 1'b1) begin n_err++; $display("FAIL mrst_fs_fire: got %b want 1", if_a.frame_start); end
      n_vec++; if (if_a.de !== 1'b1) begin n_err++; $display("FAIL mrst_de_00: got %b want 1", if_a.de); end
      goto(t0_a, 1);
      n_vec++; if (if_a.frame_start !== 1'b0) begin n_err++; $display("FAIL mrst_fs_once: got %b want 0", if_a.frame_start); end
      goto(t0_a, pos_a(0, 30, 38));
      n_vec++; if ({if_a.red, if_a.green, if_a.blue} !== 12'h000) begin n_err++; $display("FAIL mrst_black: got %h want 000", {if_a.red, if_a.green, if_a.blue}); end
      goto(t0_a, pos_a(1, 30, 38));
      n_vec++; if ({if_a.red, if_a.green, if_a.blue} !== 12'hFFF) begin n_err++; $display("FAIL mrst_recapture: got %h want FFF", {if_a.red, if_a.green, if_a.blue}); end
   endtask

   task automatic test_small();
      int          tv[10] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 4};
      int          th[10] = '{0, 2, 4, 1, 3, 0, 2, 1, 3, 0};
      logic [11:0] te[10] = '{12'hFFF, 12'h0A0, 12'h000, 12'hFFF, 12'h0A0,
                              12'h0A0, 12'hFFF, 12'h0A0, 12'hFFF, 12'h000};
      int          sv[8]  = '{5, 5, 5, 5, 9, 10, 11, 12};
      int          sh[8]  = '{17, 18, 19, 20, 0, 0, 21, 0};
      logic        shs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        svs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      if_b.fg_color = 12'hFFF;
      if_b.bg_color = 12'h0A0;
      if_b.vdata    = 4'b1001;
      clr_b = 1'b1;
      t0_b  = cyc;
      goto(t0_b, pos_b(1, 0, 0));
      n_vec++; if (if_b.frame_start !== 1'b1) begin n_err++; $display("FAIL b_fs_period: got %b want 1", if_b.frame_start); end
      for (int i = 0; i < 10; i++) begin
         goto(t0_b, pos_b(1, tv[i], th[i]));
         n_vec++;
         if ({if_b.red, if_b.green, if_b.blue} !== te[i]) begin
            n_err++;
            $display("FAIL b_pix(v=%0d,h=%0d): got %h want %h", tv[i], th[i], {if_b.red, if_b.green, if_b.blue}, te[i]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         goto(t0_b, pos_b(1, sv[i], sh[i]));
         n_vec++;
         if (if_b.hsync !== shs[i] || if_b.vsync !== svs[i]) begin
            n_err++;
            $display("FAIL b_sync(v=%0d,h=%0d): got hs=%b vs=%b want hs=%b vs=%b", sv[i], sh[i], if_b.hsync, if_b.vsync, shs[i], svs[i]);
         end
      end
   endtask

   task automatic test_scale1_edge();
      int          tv[11] = '{3, 4, 4, 4, 4, 4, 4, 5, 5, 11, 12};
      int          th[11] = '{31, 23, 24, 25, 30, 31, 32, 0, 31, 31, 31};
      logic [11:0] te[11] = '{12'h000, 12'h000, 12'hFFF, 12'h00F, 12'h00F, 12'hFFF,
                              12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h000};
      logic        tde[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      if_c.fg_color = 12'hFFF;
      if_c.bg_color = 12'h00F;
      if_c.vdata    = 64'h8181_8181_8181_8181;
      clr_c = 1'b1;
      t0_c  = cyc;
      for (int i = 0; i < 11; i++) begin
         goto(t0_c, pos_c(1, tv[i], th[i]));
         n_vec++;
         if ({if_c.red, if_c.green, if_c.blue} !== te[i] || if_c.de !== tde[i]) begin
            n_err++;
            $display("FAIL c_edge(v=%0d,h=%0d): got rgb=%h de=%b want rgb=%h de=%b", tv[i], th[i], {if_c.red, if_c.green, if_c.blue}, if_c.de, te[i], tde[i]);
         end
      end
   endtask

   initial begin
      if_a.vdata = '0; if_a.fg_color = '0; if_a.bg_color = '0;
      if_b.vdata = '0; if_b.fg_color = '0; if_b.bg_color = '0;
      if_c.vdata = '0; if_c.fg_color = '0; if_c.bg_color = '0;
      test_reset();
      test_sync_timing();
      test_image();
      test_vdata_change();
      test_midframe_reset();
      test_small();
      test_scale1_edge();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
